// File: rtl/rms_sumsq_accum.sv
// rms_sumsq_accum: streaming mean(x^2)+EPS over VEC_LEN FP32 elements.
// Optional `RMS_ACCUM_LAST_CHECK_EN adds in_last/err_last framing check.
// Also holds fp32_mul (combinational) and fp32_addsub (1-cycle registered).
// Both units flush subnormals to zero and round to nearest-even.

module fp32_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        s;
  logic [9:0]  e;
  logic [47:0] p;
  logic [22:0] m, frac;
  logic        g, st;
  logic [24:0] r;

  // Normalise the 48-bit significand product, round, then classify specials
  always_comb begin
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'd1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    r = {2'b01, m} + 25'(g & (st | m[0]));
    if (r[24]) e = e + 10'd1;
    frac = r[24] ? r[23:1] : r[22:0];
    y = {s, e[7:0], frac};
    if ((a[30:23] == 8'hff && a[22:0] != '0) || (b[30:23] == 8'hff && b[22:0] != '0) ||
        (a[30:23] == 8'hff && b[30:23] == 8'h00) || (b[30:23] == 8'hff && a[30:23] == 8'h00))
      y = 32'h7fc00000;
    else if (a[30:23] == 8'hff || b[30:23] == 8'hff) y = {s, 8'hff, 23'h0};
    else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) y = {s, 31'h0};
    else if (e[9] || e == '0)                         y = {s, 31'h0};
    else if (e >= 10'd255)                            y = {s, 8'hff, 23'h0};
  end
endmodule

module fp32_addsub (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);
  logic [31:0] bb, big, sml, res;
  logic [23:0] mbig, msml;
  logic [7:0]  d;
  logic [5:0]  dc, p;
  logic [49:0] ext, sh;
  logic        stk, g, st;
  logic [50:0] sum, n;
  logic [9:0]  e;
  logic [22:0] m, frac;
  logic [24:0] r;

  // Align smaller operand with sticky in bit 0, add/sub, renormalise, round
  always_comb begin
    bb   = {b[31] ^ sub, b[30:0]};
    big  = (a[30:0] < bb[30:0]) ? bb : a;
    sml  = (a[30:0] < bb[30:0]) ? a  : bb;
    mbig = (big[30:23] == '0) ? '0 : {1'b1, big[22:0]};
    msml = (sml[30:23] == '0) ? '0 : {1'b1, sml[22:0]};
    d    = big[30:23] - sml[30:23];
    dc   = (d > 8'd63) ? 6'd63 : d[5:0];
    ext  = {msml, 26'h0};
    sh   = ext >> dc;
    stk  = ((sh << dc) != ext);
    sh[0] = sh[0] | stk;
    if (big[31] == sml[31]) sum = {1'b0, mbig, 26'h0} + {1'b0, sh};
    else                    sum = {1'b0, mbig, 26'h0} - {1'b0, sh};
    p = '0;
    for (int unsigned i = 0; i < 51; i++)
      if (sum[i]) p = 6'(i);
    n = sum << (6'd50 - p);
    e = 10'(big[30:23]) + 10'(p) - 10'd49;
    m = n[49:27]; g = n[26]; st = |n[25:0];
    r = {2'b01, m} + 25'(g & (st | m[0]));
    if (r[24]) e = e + 10'd1;
    frac = r[24] ? r[23:1] : r[22:0];
    if (big[30:23] == 8'hff)  res = big;
    else if (sum == '0)       res = {a[31] & bb[31], 31'h0};
    else if (e[9] || e == '0) res = {big[31], 31'h0};
    else if (e >= 10'd255)    res = {big[31], 8'hff, 23'h0};
    else                      res = {big[31], e[7:0], frac};
  end

  // Result register; clearing it on reset discards any partial sum
  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= res;
  end
endmodule

module rms_sumsq_accum #(
  parameter int          VEC_LEN = 64,
  parameter logic [31:0] INV_N   = 32'h3c800000,
  parameter logic [31:0] EPS     = 32'h3727c5ac
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_fp32,
  output logic        out_valid,
  output logic [31:0] ms_fp32
`ifdef RMS_ACCUM_LAST_CHECK_EN
  ,
  input  logic        in_last,
  output logic        err_last
`endif
);
  localparam int CW = $clog2(VEC_LEN);

  typedef enum logic [2:0] {ACCUM, DRAIN, SCALE, BIAS, CAPTURE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   sq_r, mean_r, acc_y, bias_y, mul_a, mul_b, mul_y, acc_a, acc_b;
  logic          sq_v, sq_first, accept, last_beat;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CW'(VEC_LEN - 1));

  // One multiplier: squares beats while accumulating, scales the sum otherwise
  always_comb begin
    mul_a = in_ready ? x_fp32 : acc_y;
    mul_b = in_ready ? x_fp32 : INV_N;
  end

  // Running sum lives in the adder's output register; first square restarts it
  always_comb begin
    acc_b = sq_v ? sq_r : '0;
    acc_a = (sq_v && sq_first) ? '0 : acc_y;
  end

  fp32_mul u_mul (.a(mul_a), .b(mul_b), .y(mul_y));

  fp32_addsub u_acc (
    .clk(clk), .rst(rst), .a(acc_a), .b(acc_b), .sub(1'b0), .y(acc_y)
  );

  fp32_addsub u_bias (
    .clk(clk), .rst(rst), .a(mean_r), .b(EPS), .sub(1'b0), .y(bias_y)
  );

  // Framing FSM: accumulate VEC_LEN beats, then drain/scale/bias/capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      sq_r      <= '0;
      sq_v      <= 1'b0;
      sq_first  <= 1'b0;
      mean_r    <= '0;
      out_valid <= 1'b0;
      ms_fp32   <= '0;
    end else begin
      out_valid <= 1'b0;
      sq_v      <= accept;
      case (state)
        ACCUM: begin
          if (accept) begin
            sq_r     <= mul_y;
            sq_first <= (cnt == '0);
            cnt      <= last_beat ? '0 : cnt + CW'(1);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: state <= SCALE;
        SCALE: begin
          mean_r <= mul_y;
          state  <= BIAS;
        end
        BIAS: state <= CAPTURE;
        CAPTURE: begin
          ms_fp32   <= bias_y;
          out_valid <= 1'b1;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef RMS_ACCUM_LAST_CHECK_EN
  // Sticky flag: in_last disagreed with the counter's view of the last beat
  always_ff @(posedge clk) begin
    if (rst)                                err_last <= 1'b0;
    else if (accept && (in_last != last_beat)) err_last <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_rms_sumsq_accum.sv
// Bench for rms_sumsq_accum (VEC_LEN=4, INV_N=0.25). Integer-valued elements
// keep every sum exact, so the expected mean is encoded directly from S/4.
module tb_rms_sumsq_accum;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last;
  logic [31:0] x_fp32;
  logic        in_ready, out_valid, e_ready, e_valid, err_last, e_err_last;
  logic [31:0] ms_fp32, e_ms;

  always #5 clk = ~clk;

  rms_sumsq_accum #(.VEC_LEN(N), .INV_N(32'h3e800000), .EPS(32'h0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_fp32(x_fp32), .out_valid(out_valid), .ms_fp32(ms_fp32)
`ifdef RMS_ACCUM_LAST_CHECK_EN
    , .in_last(in_last), .err_last(err_last)
`endif
  );

  rms_sumsq_accum #(.VEC_LEN(N), .INV_N(32'h3e800000)) u_eps (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_ready),
    .x_fp32(x_fp32), .out_valid(e_valid), .ms_fp32(e_ms)
`ifdef RMS_ACCUM_LAST_CHECK_EN
    , .in_last(in_last), .err_last(e_err_last)
`endif
  );

  int vectors = 0, miscompares = 0;
  int q[$];
  int cyc = 0, blk_until = -1, due_cyc = -1, cnt_m = 0, sum_m = 0;
  int gap_pct = 0, bad_idx = -1;
  logic [31:0] pend_ms, exp_ms;
  logic        pend_zero, err_m;

  // FP32 bits of v * 2^-scale for a small integer v
  function automatic logic [31:0] enc(input int v, input int scale);
    int mag, k;
    logic [31:0] r;
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'h0;
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    r[31]    = (v < 0);
    r[30:23] = 8'(k - scale + 127);
    r[22:0]  = 23'((mag << (23 - k)) & 32'h7fffff);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cnt_m = 0; sum_m = 0; due_cyc = -1; blk_until = -1;
    exp_ms = 32'h0; pend_zero = 1'b0; err_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; x_fp32 = $urandom;
    @(posedge clk); #1;
    rst = 1'b0; cyc++;
    model_reset();
  endtask

  // Check this cycle's outputs, drive one cycle of stimulus, advance the model
  task automatic tick();
    logic exp_ready, exp_ov, accept;
    exp_ready = (cyc > blk_until);
    exp_ov    = (cyc == due_cyc);
    if (exp_ov) exp_ms = pend_ms;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("ms_fp32", ms_fp32, exp_ms);
    check("eps_out_valid", 32'(e_valid), 32'(exp_ov));
    if (exp_ov && pend_zero) check("eps_ms_zero_vec", e_ms, 32'h3727c5ac);
`ifdef RMS_ACCUM_LAST_CHECK_EN
    check("err_last", 32'(err_last), 32'(err_m));
`endif
    if (q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      in_valid = 1'b1;
      x_fp32   = enc(q[0], 0);
    end else begin
      in_valid = 1'b0;
      x_fp32   = $urandom;
    end
    in_last = (bad_idx >= 0) ? (cnt_m == bad_idx) : (cnt_m == N - 1);
    accept = in_valid && exp_ready;
    if (accept) begin
      if (in_last != (cnt_m == N - 1)) err_m = 1'b1;
      sum_m += q[0] * q[0];
      void'(q.pop_front());
      cnt_m++;
      if (cnt_m == N) begin
        pend_ms   = enc(sum_m, 2);
        pend_zero = (sum_m == 0);
        due_cyc   = cyc + 5;
        blk_until = cyc + 4;
        cnt_m = 0; sum_m = 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_vectors();
    int n;
    n = 0;
    while ((q.size() > 0 || cyc <= due_cyc) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; x_fp32 = '0;
    model_reset();
    do_reset();
    do_reset();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_ms", ms_fp32, 32'h0);

    // 1,2,3,4 back-to-back
    gap_pct = 0;
    q = '{1, 2, 3, 4};
    run_vectors();
    check("dir_1234", ms_fp32, 32'h40f00000);

    // negative elements: sign must not matter
    q = '{-1, -2, -3, -4};
    run_vectors();
    check("dir_neg1234", ms_fp32, 32'h40f00000);

    // zero vector: eps instance yields exactly EPS
    q = '{0, 0, 0, 0};
    run_vectors();
    check("dir_zero_eps", e_ms, 32'h3727c5ac);

    // in_valid held across two vectors and the in_ready-low window
    q = '{1, 2, 3, 4, 2, 2, 2, 2};
    run_vectors();
    check("dir_two_vec", ms_fp32, 32'h40800000);

    // abort mid-vector with reset, then a clean vector of ones
    q = '{5, 7};
    run_vectors();
    do_reset();
    check("abort_ms_cleared", ms_fp32, 32'h0);
    q = '{1, 1, 1, 1};
    run_vectors();
    check("dir_after_abort", ms_fp32, 32'h3f800000);

`ifdef RMS_ACCUM_LAST_CHECK_EN
    // in_last asserted on beat index 1: flag sticks until reset
    bad_idx = 1;
    q = '{1, 2, 3, 4};
    run_vectors();
    check("err_last_sticky", 32'(err_last), 32'd1);
    bad_idx = -1;
    do_reset();
    check("err_last_cleared", 32'(err_last), 32'd0);
`endif

    // randomized vectors with random in_valid gaps
    gap_pct = 30;
    for (int v = 0; v < 25; v++)
      for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(30)) - 15);
    run_vectors();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
